// File: rtl/fetch_queue_if.sv
// fetch_queue_if -- instruction-memory fetch bus between fetch_queue and imem.
//   imem_req    : fetch request for the word pair at imem_addr
//   imem_addr   : word address of the first word of the pair
//   imem_valid  : response valid, one cycle after an accepted request
//   imem_rdata1 : instruction at imem_addr
//   imem_rdata2 : instruction at imem_addr+1
// master = fetch queue side, slave = memory side.
interface fetch_queue_if;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_valid;
   logic [15:0] imem_rdata1;
   logic [15:0] imem_rdata2;

   modport master (output imem_req, imem_addr,
                   input  imem_valid, imem_rdata1, imem_rdata2);
   modport slave  (input  imem_req, imem_addr,
                   output imem_valid, imem_rdata1, imem_rdata2);
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue -- instruction prefetch queue.
// Fetches word pairs from imem into a DEPTH-entry circular queue and presents
// the two oldest entries to the downstream relayer, which consumes 0/1/2 per
// cycle. A redirect flushes the queue and restarts fetch at redirect_pc.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   redirect_valid/pc : flush and restart fetch stream at redirect_pc
//   imem              : fetch bus (fetch_queue_if.master)
//   isstall           : consume nothing this cycle (wins over issingleinstr)
//   issingleinstr     : consume one entry this cycle (else two)
//   instr1_o/instr2_o : two oldest entries, 16'h0000 when not present
//   pc1_o             : word address of instr1_o
//   count_o           : number of valid entries
// Optional: define FETCHQ_PERF_EN to add stall_cnt_o / starve_cnt_o
// saturating performance counters.
module fetch_queue #(
   parameter int          DEPTH    = 8,
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     redirect_valid,
   input  logic [15:0]              redirect_pc,
   fetch_queue_if.master            imem,
   input  logic                     isstall,
   input  logic                     issingleinstr,
   output logic [15:0]              instr1_o,
   output logic [15:0]              instr2_o,
   output logic [15:0]              pc1_o,
   output logic [$clog2(DEPTH):0]   count_o
`ifdef FETCHQ_PERF_EN
   ,
   output logic [15:0]              stall_cnt_o,
   output logic [15:0]              starve_cnt_o
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [15:0]   mem [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic [15:0]   pc1, fetch_pc;
   logic          outstanding;

   logic [1:0]    want;
   logic [CW-1:0] consume;
   logic          push;
   logic          req;

   always_comb begin
      want = 2'd2;
      if (isstall)            want = 2'd0;
      else if (issingleinstr) want = 2'd1;
      consume = (CW'(want) > count) ? count : CW'(want);
      // A response is only trusted when we issued the request last cycle;
      // stray valids and responses cancelled by reset/redirect are dropped.
      push = imem.imem_valid && outstanding && !redirect_valid;
      // Space check ignores this cycle's consumption on purpose: a request
      // needs room for two words when its response lands.
      req  = rst_n && !outstanding && !redirect_valid &&
             (count <= CW'(DEPTH - 2));
   end

   assign imem.imem_req  = req;
   assign imem.imem_addr = fetch_pc;
   assign instr1_o = (count != '0)      ? mem[rd_ptr]          : 16'h0000;
   assign instr2_o = (count > CW'(1))   ? mem[rd_ptr + PW'(1)] : 16'h0000;
   assign pc1_o    = pc1;
   assign count_o  = count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         pc1         <= RESET_PC;
         fetch_pc    <= RESET_PC;
         outstanding <= 1'b0;
      end else if (redirect_valid) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         pc1         <= redirect_pc;
         fetch_pc    <= redirect_pc;
         outstanding <= 1'b0;
      end else begin
         rd_ptr      <= rd_ptr + consume[PW-1:0];
         pc1         <= pc1 + 16'(consume);
         count       <= count - consume + (push ? CW'(2) : CW'(0));
         if (push) wr_ptr <= wr_ptr + PW'(2);
         outstanding <= req;
         if (req) fetch_pc <= fetch_pc + 16'd2;
      end
   end

   // Queue storage carries no reset; validity is tracked by count.
   always_ff @(posedge clk) begin
      if (rst_n && push) begin
         mem[wr_ptr]          <= imem.imem_rdata1;
         mem[wr_ptr + PW'(1)] <= imem.imem_rdata2;
      end
   end

`ifdef FETCHQ_PERF_EN
   // Saturating counters; survive redirects, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt_o  <= '0;
         starve_cnt_o <= '0;
      end else begin
         if (isstall && stall_cnt_o != 16'hFFFF)
            stall_cnt_o <= stall_cnt_o + 16'd1;
         if (count < CW'(2) && starve_cnt_o != 16'hFFFF)
            starve_cnt_o <= starve_cnt_o + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue -- self-checking bench for fetch_queue (DEPTH=8).
// A directed vector table from reset, hand sequences for stray responses and
// reset during a request, then randomized traffic against a queue-based model.
module tb_fetch_queue;
   localparam int          DEPTH    = 8;
   localparam logic [15:0] RESET_PC = 16'h0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n = 1'b0, redirect_valid = 1'b0, isstall = 1'b0, issingleinstr = 1'b0;
   logic [15:0] redirect_pc = '0;
   logic [15:0] instr1_o, instr2_o, pc1_o;
   logic [$clog2(DEPTH):0] count_o;
`ifdef FETCHQ_PERF_EN
   logic [15:0] stall_cnt_o, starve_cnt_o;
`endif

   fetch_queue_if bus();

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem(bus.master), .isstall(isstall), .issingleinstr(issingleinstr),
      .instr1_o(instr1_o), .instr2_o(instr2_o), .pc1_o(pc1_o), .count_o(count_o)
`ifdef FETCHQ_PERF_EN
      , .stall_cnt_o(stall_cnt_o), .starve_cnt_o(starve_cnt_o)
`endif
   );

   // Memory image: 0 -> 1111, 1 -> 2222, otherwise A000+addr.
   function automatic logic [15:0] w(input logic [15:0] a);
      if (a == 16'd0) return 16'h1111;
      if (a == 16'd1) return 16'h2222;
      return 16'hA000 + a;
   endfunction

   // Memory responder: answers every request exactly one cycle later.
   logic resp_v = 1'b0, stray = 1'b0;
   always @(posedge clk) begin
      resp_v           <= bus.imem_req;
      bus.imem_rdata1  <= w(bus.imem_addr);
      bus.imem_rdata2  <= w(bus.imem_addr + 16'd1);
   end
   assign bus.imem_valid = resp_v | stray;

   int ncmp = 0, nerr = 0;
   task automatic chk(input string nm, input int act, input int exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a queue of instruction words plus a few scalars.
   logic [15:0] mq[$];
   logic [15:0] m_pc1, m_fpc, m_paddr;
   bit          m_out, m_live;
   int          m_stall, m_starve;
   bit          c_r, c_rd, c_st, c_si, c_iv, e_req;
   logic [15:0] c_rpc;

   task automatic drive(input bit r, input bit rd, input logic [15:0] rpc,
                        input bit st, input bit si, input bit sv);
      @(negedge clk);
      rst_n = r; redirect_valid = rd; redirect_pc = rpc;
      isstall = st; issingleinstr = si; stray = sv && !resp_v;
      c_r = r; c_rd = rd; c_rpc = rpc; c_st = st; c_si = si;
      #1;
      c_iv  = bus.imem_valid;
      e_req = r && !m_out && !rd && (mq.size() <= DEPTH - 2);
      chk("imem_req", int'(bus.imem_req), int'(e_req));
      if (r && m_live) begin
         chk("imem_addr", bus.imem_addr, m_fpc);
         chk("count", count_o, mq.size());
         chk("count_bound", int'(count_o <= DEPTH), 1);
         chk("instr1", instr1_o, (mq.size() >= 1) ? mq[0] : 16'h0000);
         chk("instr2", instr2_o, (mq.size() >= 2) ? mq[1] : 16'h0000);
         chk("pc1", pc1_o, m_pc1);
`ifdef FETCHQ_PERF_EN
         chk("stall_cnt", stall_cnt_o, m_stall);
         chk("starve_cnt", starve_cnt_o, m_starve);
`endif
      end
   endtask

   task automatic tick();
      int n;
      @(posedge clk);
      if (!c_r) begin
         mq.delete(); m_pc1 = RESET_PC; m_fpc = RESET_PC; m_out = 0;
         m_stall = 0; m_starve = 0; m_live = 1;
      end else begin
         if (c_st && m_stall < 65535) m_stall++;
         if (mq.size() < 2 && m_starve < 65535) m_starve++;
         if (c_rd) begin
            mq.delete(); m_pc1 = c_rpc; m_fpc = c_rpc; m_out = 0;
         end else begin
            n = c_st ? 0 : (c_si ? 1 : 2);
            if (n > mq.size()) n = mq.size();
            repeat (n) void'(mq.pop_front());
            m_pc1 = m_pc1 + 16'(n);
            if (m_out && c_iv) begin
               mq.push_back(w(m_paddr));
               mq.push_back(w(m_paddr + 16'd1));
            end
            if (e_req) begin m_paddr = m_fpc; m_fpc = m_fpc + 16'd2; end
            m_out = e_req;
         end
      end
   endtask

   typedef struct {
      bit rd; logic [15:0] rpc; bit st; bit si;
      bit e_req; logic [15:0] e_addr; int e_cnt;
      logic [15:0] e_i1; logic [15:0] e_i2; logic [15:0] e_pc;
   } vec_t;
   vec_t tv[23];

   initial begin
      //        rd rpc      st si  req addr      cnt i1        i2        pc1
      tv[0]  = '{0, 16'h0,  1, 0,  1, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000};
      tv[1]  = '{0, 16'h0,  1, 0,  0, 16'h0002, 0, 16'h0000, 16'h0000, 16'h0000};
      tv[2]  = '{0, 16'h0,  1, 0,  1, 16'h0002, 2, 16'h1111, 16'h2222, 16'h0000};
      tv[3]  = '{0, 16'h0,  1, 0,  0, 16'h0004, 2, 16'h1111, 16'h2222, 16'h0000};
      tv[4]  = '{0, 16'h0,  1, 0,  1, 16'h0004, 4, 16'h1111, 16'h2222, 16'h0000};
      tv[5]  = '{0, 16'h0,  1, 0,  0, 16'h0006, 4, 16'h1111, 16'h2222, 16'h0000};
      tv[6]  = '{0, 16'h0,  1, 0,  1, 16'h0006, 6, 16'h1111, 16'h2222, 16'h0000};
      tv[7]  = '{0, 16'h0,  1, 0,  0, 16'h0008, 6, 16'h1111, 16'h2222, 16'h0000};
      tv[8]  = '{0, 16'h0,  1, 0,  0, 16'h0008, 8, 16'h1111, 16'h2222, 16'h0000};
      tv[9]  = '{0, 16'h0,  0, 1,  0, 16'h0008, 8, 16'h1111, 16'h2222, 16'h0000};
      tv[10] = '{0, 16'h0,  0, 0,  0, 16'h0008, 7, 16'h2222, 16'hA002, 16'h0001};
      tv[11] = '{0, 16'h0,  1, 1,  1, 16'h0008, 5, 16'hA003, 16'hA004, 16'h0003};
      tv[12] = '{0, 16'h0,  0, 0,  0, 16'h000A, 5, 16'hA003, 16'hA004, 16'h0003};
      tv[13] = '{0, 16'h0,  1, 0,  1, 16'h000A, 5, 16'hA005, 16'hA006, 16'h0005};
      tv[14] = '{0, 16'h0,  1, 0,  0, 16'h000C, 5, 16'hA005, 16'hA006, 16'h0005};
      tv[15] = '{0, 16'h0,  0, 0,  0, 16'h000C, 7, 16'hA005, 16'hA006, 16'h0005};
      tv[16] = '{0, 16'h0,  1, 0,  1, 16'h000C, 5, 16'hA007, 16'hA008, 16'h0007};
      tv[17] = '{1, 16'h40, 0, 0,  0, 16'h000E, 5, 16'hA007, 16'hA008, 16'h0007};
      tv[18] = '{0, 16'h0,  0, 0,  1, 16'h0040, 0, 16'h0000, 16'h0000, 16'h0040};
      tv[19] = '{0, 16'h0,  0, 0,  0, 16'h0042, 0, 16'h0000, 16'h0000, 16'h0040};
      tv[20] = '{0, 16'h0,  0, 1,  1, 16'h0042, 2, 16'hA040, 16'hA041, 16'h0040};
      tv[21] = '{0, 16'h0,  0, 0,  0, 16'h0044, 1, 16'hA041, 16'h0000, 16'h0041};
      tv[22] = '{0, 16'h0,  1, 0,  1, 16'h0044, 2, 16'hA042, 16'hA043, 16'h0042};

      // Reset: imem_req must stay low throughout.
      repeat (3) begin drive(0, 0, 16'h0, 0, 0, 0); tick(); end

      foreach (tv[i]) begin
         drive(1, tv[i].rd, tv[i].rpc, tv[i].st, tv[i].si, 0);
         chk("tv_req",  int'(bus.imem_req), int'(tv[i].e_req));
         chk("tv_addr", bus.imem_addr, tv[i].e_addr);
         chk("tv_cnt",  count_o, tv[i].e_cnt);
         chk("tv_i1",   instr1_o, tv[i].e_i1);
         chk("tv_i2",   instr2_o, tv[i].e_i2);
         chk("tv_pc1",  pc1_o, tv[i].e_pc);
         tick();
      end

      // Fill to 8 under stall, then a stray valid with nothing outstanding.
      repeat (6) begin drive(1, 0, 16'h0, 1, 0, 0); tick(); end
      drive(1, 0, 16'h0, 1, 0, 1);
      chk("full_cnt", count_o, 8);
      chk("full_noreq", int'(bus.imem_req), 0);
      tick();
      drive(1, 0, 16'h0, 1, 0, 0);
      chk("stray_ignored", count_o, 8);
      tick();

      // Reset while a request is outstanding; its response must be dropped.
      drive(1, 1, 16'h0100, 1, 0, 0); tick();
      drive(1, 0, 16'h0, 1, 0, 0);
      chk("pre_rst_req", int'(bus.imem_req), 1);
      chk("pre_rst_addr", bus.imem_addr, 16'h0100);
      tick();
      drive(0, 0, 16'h0, 1, 0, 0); tick();
      drive(0, 0, 16'h0, 1, 0, 0); tick();
      drive(1, 0, 16'h0, 1, 0, 0);
      chk("post_rst_cnt", count_o, 0);
      chk("post_rst_i1", instr1_o, 16'h0000);
      chk("post_rst_i2", instr2_o, 16'h0000);
      chk("post_rst_pc", pc1_o, RESET_PC);
      chk("post_rst_addr", bus.imem_addr, RESET_PC);
      tick();

      // Randomized traffic.
      for (int k = 0; k < 3000; k++) begin
         drive(($urandom % 300) != 0, ($urandom % 20) == 0, 16'($urandom),
               ($urandom % 4) == 0, ($urandom % 3) == 0, ($urandom % 10) == 0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
